// File: rtl/spi_pwm_bank.sv
// spi_pwm_bank: decoded SPI command sink driving a bank of PWM channels.
// Period-aligned duty update, fade-to-target engine, readback and status.
module spi_pwm_bank #(
  parameter int NUM_CH   = 8,
  parameter int CMD_W    = 8,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int BRIGHT_W = 7,
  parameter int PRESCALE = 1,
  parameter int FADE_DIV = 1
) (
  input  logic                            sysclk,
  input  logic                            rst_n,
  input  logic                            i_rx_dv,
  input  logic [CMD_W-1:0]                i_cmd,
  input  logic [ADDR_W-1:0]               i_addr,
  input  logic [DATA_W-1:0]               i_payload,
  input  logic                            i_tx_ack,
  output logic                            o_tx_enb,
  output logic [CMD_W+ADDR_W+DATA_W-1:0]  o_tx_frame,
  output logic [NUM_CH-1:0]               o_pwm,
  output logic                            o_busy,
  output logic                            o_err
);

  localparam int CNT_LAST = (1 << BRIGHT_W) - 2;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [CMD_W-1:0] OP_NOP    = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_SET    = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_READ   = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_SETALL = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_FADE   = CMD_W'(4);
  localparam logic [CMD_W-1:0] OP_STATUS = CMD_W'(5);

  logic [PS_W-1:0]     ps_cnt;
  logic [BRIGHT_W-1:0] cnt;
  logic [FD_W-1:0]     fd_cnt;
  logic                tick;
  logic                wrap;
  logic                fade_tick;

  logic [BRIGHT_W-1:0] duty   [NUM_CH];
  logic [BRIGHT_W-1:0] shadow [NUM_CH];
  logic [BRIGHT_W-1:0] target [NUM_CH];

  logic                op_set;
  logic                op_read;
  logic                op_setall;
  logic                op_fade;
  logic                op_status;
  logic                op_bad;
  logic                addr_ok;
  logic                err_set;
  logic [BRIGHT_W-1:0] b;
  logic [BRIGHT_W-1:0] rd_duty;
  logic [NUM_CH-1:0]   sel;
  logic [NUM_CH-1:0]   wr_sh;
  logic [NUM_CH-1:0]   wr_tg;
  logic [NUM_CH-1:0]   pwm_nx;
  logic                any_diff;
  logic                unused_ok;

  assign unused_ok = &{1'b0, i_payload};

  assign b    = i_payload[BRIGHT_W-1:0];
  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));
  assign wrap = tick && (cnt == BRIGHT_W'(CNT_LAST));
  assign fade_tick = wrap && (fd_cnt == FD_W'(FADE_DIV - 1));

  // Prescaler: one PWM tick every PRESCALE sysclk cycles.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // PWM counter: 0..2^BRIGHT_W-2, so full-scale duty stays high.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + BRIGHT_W'(1);
    end
  end

  // Fade divider: counts period starts between fade steps.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      fd_cnt <= '0;
    end else if (wrap) begin
      fd_cnt <= fade_tick ? '0 : fd_cnt + FD_W'(1);
    end
  end

  // Opcode decode, qualified by the frame-valid strobe.
  always_comb begin
    op_set    = 1'b0;
    op_read   = 1'b0;
    op_setall = 1'b0;
    op_fade   = 1'b0;
    op_status = 1'b0;
    op_bad    = 1'b0;
    if (i_rx_dv) begin
      unique case (i_cmd)
        OP_NOP:    ;
        OP_SET:    op_set    = 1'b1;
        OP_READ:   op_read   = 1'b1;
        OP_SETALL: op_setall = 1'b1;
        OP_FADE:   op_fade   = 1'b1;
        OP_STATUS: op_status = 1'b1;
        default:   op_bad    = 1'b1;
      endcase
    end
  end

  // Channel select; an out-of-range address selects nothing.
  always_comb begin
    addr_ok = (32'(i_addr) < 32'(NUM_CH));
    sel     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel[k] = (32'(i_addr) == 32'(k));
    end
    wr_sh   = ({NUM_CH{op_set}} & sel) | {NUM_CH{op_setall}};
    wr_tg   = wr_sh | ({NUM_CH{op_fade}} & sel);
    err_set = op_bad |
              ((op_set | op_read | op_fade) & ~addr_ok);
  end

  // Readback mux of the active duty; zero when no channel matches.
  always_comb begin
    rd_duty = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel[k]) begin
        rd_duty = duty[k];
      end
    end
  end

  // Register file: writes beat fade steps; duty loads at period start.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        duty[k]   <= '0;
        shadow[k] <= '0;
        target[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_tg[k]) begin
          target[k] <= b;
        end
        if (wr_sh[k]) begin
          shadow[k] <= b;
        end else if (fade_tick && !wr_tg[k]
                     && shadow[k] != target[k]) begin
          if (shadow[k] < target[k]) begin
            shadow[k] <= shadow[k] + BRIGHT_W'(1);
          end else begin
            shadow[k] <= shadow[k] - BRIGHT_W'(1);
          end
        end
        if (wrap) begin
          duty[k] <= shadow[k];
        end
      end
    end
  end

  // Compare stage for outputs and fade activity.
  always_comb begin
    any_diff = 1'b0;
    pwm_nx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pwm_nx[k] = (cnt < duty[k]);
      if (shadow[k] != target[k]) begin
        any_diff = 1'b1;
      end
    end
  end

  // Registered PWM pins and busy flag.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      o_pwm  <= '0;
      o_busy <= 1'b0;
    end else begin
      o_pwm  <= pwm_nx;
      o_busy <= any_diff;
    end
  end

  // Response frame: a new READ/STATUS wins over a same-cycle ack.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      o_tx_enb   <= 1'b0;
      o_tx_frame <= '0;
    end else if (op_read) begin
      o_tx_enb   <= 1'b1;
      o_tx_frame <= {OP_READ, i_addr, DATA_W'(rd_duty)};
    end else if (op_status) begin
      o_tx_enb   <= 1'b1;
      o_tx_frame <= {OP_STATUS, ADDR_W'(0),
                     DATA_W'({o_err, o_busy})};
    end else if (i_tx_ack) begin
      o_tx_enb   <= 1'b0;
    end
  end

  // Sticky error, cleared when a status frame reports it.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if (err_set) begin
      o_err <= 1'b1;
    end else if (op_status) begin
      o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// tb_spi_pwm_bank: directed checks of spi_pwm_bank with default params.
// Period 127 sysclk (PRESCALE=1), fade step every period.
module tb_spi_pwm_bank;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx_dv = 1'b0;
  logic [7:0]  i_cmd = '0;
  logic [7:0]  i_addr = '0;
  logic [7:0]  i_payload = '0;
  logic        i_tx_ack = 1'b0;
  logic        o_tx_enb;
  logic [23:0] o_tx_frame;
  logic [7:0]  o_pwm;
  logic        o_busy;
  logic        o_err;

  int tests = 0;
  int fails = 0;

  spi_pwm_bank dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .i_rx_dv    (i_rx_dv),
    .i_cmd      (i_cmd),
    .i_addr     (i_addr),
    .i_payload  (i_payload),
    .i_tx_ack   (i_tx_ack),
    .o_tx_enb   (o_tx_enb),
    .o_tx_frame (o_tx_frame),
    .o_pwm      (o_pwm),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [7:0] c,
                     input logic [7:0] a,
                     input logic [7:0] p);
    @(negedge sysclk);
    i_cmd = c;
    i_addr = a;
    i_payload = p;
    i_rx_dv = 1'b1;
    @(negedge sysclk);
    i_rx_dv = 1'b0;
  endtask

  task automatic ack();
    @(negedge sysclk);
    i_tx_ack = 1'b1;
    @(negedge sysclk);
    i_tx_ack = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic ones(input int ch, output int n,
                      output logic [7:0] orv);
    n = 0;
    orv = '0;
    repeat (127) begin
      @(negedge sysclk);
      n += int'(o_pwm[ch]);
      orv |= o_pwm;
    end
  endtask

  int         n;
  int         len;
  logic [7:0] orv;
  logic       p3;
  logic       found;

  initial begin
    #23;
    check("rst_pwm", 32'(o_pwm), 32'h0);
    check("rst_enb", 32'(o_tx_enb), 32'h0);
    check("rst_frame", 32'(o_tx_frame), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    @(negedge sysclk);
    rst_n = 1'b1;
    cycles(3);
    check("idle_pwm", 32'(o_pwm), 32'h0);

    cmd(8'h01, 8'h03, 8'h40);
    cycles(254);
    ones(3, n, orv);
    check("ch3_high_64", 32'(n), 32'd64);
    check("others_low", 32'(orv & 8'hF7), 32'h0);

    cmd(8'h01, 8'h05, 8'h7F);
    cycles(254);
    ones(5, n, orv);
    check("ch5_full", 32'(n), 32'd127);
    cmd(8'h01, 8'h05, 8'h00);
    check("ch5_hold", 32'(o_pwm[5]), 32'h1);
    p3 = o_pwm[3];
    found = 1'b0;
    for (int i = 0; i < 260; i++) begin
      @(negedge sysclk);
      if (!found && !o_pwm[5]) begin
        found = 1'b1;
        check("ch5_fall_at_start", 32'({p3, o_pwm[3]}), 32'b01);
      end
      p3 = o_pwm[3];
    end
    check("ch5_fell", 32'(found), 32'h1);
    ones(5, n, orv);
    check("ch5_zero", 32'(n), 32'd0);

    cmd(8'h02, 8'h03, 8'h00);
    check("rd_enb", 32'(o_tx_enb), 32'h1);
    check("rd_frame", 32'(o_tx_frame), 32'h020340);
    cycles(3);
    check("rd_hold_enb", 32'(o_tx_enb), 32'h1);
    check("rd_hold_frame", 32'(o_tx_frame), 32'h020340);
    ack();
    check("ack_clr", 32'(o_tx_enb), 32'h0);
    ack();
    check("ack_idle", 32'(o_tx_enb), 32'h0);
    cmd(8'h02, 8'h03, 8'h00);
    cmd(8'h02, 8'h05, 8'h00);
    check("ovr_enb", 32'(o_tx_enb), 32'h1);
    check("ovr_frame", 32'(o_tx_frame), 32'h020500);
    @(negedge sysclk);
    i_tx_ack = 1'b1;
    i_cmd = 8'h02;
    i_addr = 8'h03;
    i_rx_dv = 1'b1;
    @(negedge sysclk);
    i_tx_ack = 1'b0;
    i_rx_dv = 1'b0;
    check("ackrd_enb", 32'(o_tx_enb), 32'h1);
    check("ackrd_frame", 32'(o_tx_frame), 32'h020340);
    ack();

    cmd(8'h03, 8'h00, 8'h9F);
    cmd(8'h01, 8'h02, 8'hC5);
    cycles(260);
    cmd(8'h02, 8'h07, 8'h00);
    check("setall_rd", 32'(o_tx_frame), 32'h02071F);
    cmd(8'h02, 8'h02, 8'h00);
    check("mask_rd", 32'(o_tx_frame), 32'h020245);
    ack();
    cmd(8'h03, 8'h00, 8'h00);
    cycles(260);

    cmd(8'h04, 8'h00, 8'h0A);
    n = 0;
    while (!o_busy && n < 5) begin
      @(negedge sysclk);
      n++;
    end
    check("fade_busy", 32'(o_busy), 32'h1);
    len = 0;
    while (o_busy && len < 2000) begin
      @(negedge sysclk);
      len++;
    end
    check("fade_len", 32'(len >= 1144 && len <= 1270), 32'h1);
    cycles(260);
    ones(0, n, orv);
    check("fade_high_10", 32'(n), 32'd10);
    cmd(8'h02, 8'h00, 8'h00);
    check("fade_rd", 32'(o_tx_frame), 32'h02000A);
    ack();

    cmd(8'h01, 8'h09, 8'h55);
    check("badaddr_err", 32'(o_err), 32'h1);
    cmd(8'h02, 8'h01, 8'h00);
    check("ch1_unchanged", 32'(o_tx_frame), 32'h020100);
    cmd(8'h02, 8'h09, 8'h00);
    check("badrd_frame", 32'(o_tx_frame), 32'h020900);
    ack();
    cmd(8'h05, 8'h00, 8'h00);
    check("stat_enb", 32'(o_tx_enb), 32'h1);
    check("stat_frame", 32'(o_tx_frame), 32'h050002);
    check("stat_err_clr", 32'(o_err), 32'h0);
    ack();
    cmd(8'h7E, 8'h00, 8'h00);
    check("badop_err", 32'(o_err), 32'h1);
    cmd(8'h05, 8'h00, 8'h00);
    check("stat2_frame", 32'(o_tx_frame), 32'h050002);
    ack();

    cmd(8'h04, 8'h01, 8'h7F);
    cycles(300);
    check("fade1_busy", 32'(o_busy), 32'h1);
    cmd(8'h02, 8'h03, 8'h00);
    cmd(8'h7E, 8'h00, 8'h00);
    check("pre_rst_enb", 32'(o_tx_enb), 32'h1);
    check("pre_rst_err", 32'(o_err), 32'h1);
    @(negedge sysclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", 32'(o_pwm), 32'h0);
    check("arst_busy", 32'(o_busy), 32'h0);
    check("arst_enb", 32'(o_tx_enb), 32'h0);
    check("arst_err", 32'(o_err), 32'h0);
    @(negedge sysclk);
    rst_n = 1'b1;
    cycles(3);
    check("post_rst_busy", 32'(o_busy), 32'h0);
    cmd(8'h02, 8'h01, 8'h00);
    check("post_rst_rd", 32'(o_tx_frame), 32'h020100);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
